gelato_ifetch: RTL and testbench

- Instruction-fetch stage, directly downstream of the fetch scheduler.
- Accepts one selected (pc, warp_num, split_table_num) per handshake and issues a single-word read to the instruction cache.
- Captures the returned instruction and presents it, with its tags, to decode through a valid/ready handshake.
- One fetch in flight at a time. The stage supports flush, which squashes the in-flight fetch.

---
 rtl/gelato_ifetch.sv | 118 +++++++++++
 tb/tb_gelato_ifetch.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gelato_ifetch.sv
// gelato_ifetch: single-outstanding instruction fetch stage between scheduler and decode.
// Optional misaligned-pc fault path enabled by GELATO_IFETCH_ALIGN_CHECK_EN.
module gelato_ifetch #(
  parameter int ADDR_WIDTH      = 32,
  parameter int INST_WIDTH      = 32,
  parameter int WARP_NUM_WIDTH  = 5,
  parameter int SPLIT_NUM_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       skd_valid,
  input  logic [ADDR_WIDTH-1:0]      skd_pc,
  input  logic [WARP_NUM_WIDTH-1:0]  skd_warp_num,
  input  logic [SPLIT_NUM_WIDTH-1:0] skd_split_table_num,
  output logic                       skd_ready,
  output logic                       icache_req_valid,
  output logic [ADDR_WIDTH-1:0]      icache_req_addr,
  input  logic                       icache_req_ready,
  input  logic                       icache_rsp_valid,
  input  logic [INST_WIDTH-1:0]      icache_rsp_data,
  input  logic                       flush,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [INST_WIDTH-1:0]      dec_inst,
  output logic [ADDR_WIDTH-1:0]      dec_pc,
  output logic [WARP_NUM_WIDTH-1:0]  dec_warp_num,
  output logic [SPLIT_NUM_WIDTH-1:0] dec_split_table_num,
  output logic                       dec_fault
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    OUT,
    DRAIN
  } state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0]      pc_q;
  logic [WARP_NUM_WIDTH-1:0]  warp_q;
  logic [SPLIT_NUM_WIDTH-1:0] split_q;
  logic [INST_WIDTH-1:0]      inst_q;
  logic                       fault_q;
  logic                       accept;
  logic                       misalign;
  logic                       rsp_take;

`ifdef GELATO_IFETCH_ALIGN_CHECK_EN
  assign misalign = |skd_pc[1:0];
`else
  assign misalign = 1'b0;
`endif

  // rst gates ready so every output reads 0 while reset is held
  assign skd_ready = (state == IDLE) && !flush && !rst;
  assign accept    = skd_valid && skd_ready;
  assign rsp_take  = (state == WAIT) && icache_rsp_valid && !flush;

  assign icache_req_valid    = (state == REQ);
  assign icache_req_addr     = pc_q;
  assign dec_valid           = (state == OUT);
  assign dec_inst            = inst_q;
  assign dec_pc              = pc_q;
  assign dec_warp_num        = warp_q;
  assign dec_split_table_num = split_q;
  assign dec_fault           = fault_q && dec_valid;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = misalign ? OUT : REQ;
      end
      REQ: begin
        if (icache_req_ready) state_nx = flush ? DRAIN : WAIT;
        else if (flush)       state_nx = IDLE;
      end
      WAIT: begin
        if (flush)                 state_nx = icache_rsp_valid ? IDLE : DRAIN;
        else if (icache_rsp_valid) state_nx = OUT;
      end
      DRAIN: begin
        if (icache_rsp_valid) state_nx = IDLE;
      end
      OUT: begin
        if (flush || dec_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      warp_q  <= '0;
      split_q <= '0;
      inst_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      if (accept) begin
        pc_q    <= skd_pc;
        warp_q  <= skd_warp_num;
        split_q <= skd_split_table_num;
        fault_q <= misalign;
        if (misalign) inst_q <= '0;
      end
      if (rsp_take) inst_q <= icache_rsp_data;
    end
  end

endmodule

// File: tb/tb_gelato_ifetch.sv
// tb_gelato_ifetch: directed scoreboard bench for the gelato_ifetch stage.
// Stimulus pushes expected decode beats; a negedge monitor pops and compares.
module tb_gelato_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        skd_valid;
  logic [31:0] skd_pc;
  logic [4:0]  skd_warp_num;
  logic [3:0]  skd_split_table_num;
  logic        skd_ready;
  logic        icache_req_valid;
  logic [31:0] icache_req_addr;
  logic        icache_req_ready;
  logic        icache_rsp_valid;
  logic [31:0] icache_rsp_data;
  logic        flush;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic [4:0]  dec_warp_num;
  logic [3:0]  dec_split_table_num;
  logic        dec_fault;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [4:0]  warp;
    logic [3:0]  split;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  gelato_ifetch dut (
    .clk                 (clk),
    .rst                 (rst),
    .skd_valid           (skd_valid),
    .skd_pc              (skd_pc),
    .skd_warp_num        (skd_warp_num),
    .skd_split_table_num (skd_split_table_num),
    .skd_ready           (skd_ready),
    .icache_req_valid    (icache_req_valid),
    .icache_req_addr     (icache_req_addr),
    .icache_req_ready    (icache_req_ready),
    .icache_rsp_valid    (icache_rsp_valid),
    .icache_rsp_data     (icache_rsp_data),
    .flush               (flush),
    .dec_valid           (dec_valid),
    .dec_ready           (dec_ready),
    .dec_inst            (dec_inst),
    .dec_pc              (dec_pc),
    .dec_warp_num        (dec_warp_num),
    .dec_split_table_num (dec_split_table_num),
    .dec_fault           (dec_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] p,
                      input logic [4:0] w, input logic [3:0] s,
                      input logic f);
    exp_t e;
    e.inst = i; e.pc = p; e.warp = w; e.split = s; e.fault = f;
    exp_q.push_back(e);
  endtask

  task automatic offer(input logic [31:0] p, input logic [4:0] w,
                       input logic [3:0] s);
    skd_valid = 1'b1;
    skd_pc = p;
    skd_warp_num = w;
    skd_split_table_num = s;
  endtask

  // Accepted decode beats are those with valid & ready and no flush
  always @(negedge clk) begin
    if (!rst && dec_valid && dec_ready && !flush) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_dec", {32'd0, dec_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("dec_inst",  {32'd0, dec_inst}, {32'd0, e.inst});
        chk("dec_pc",    {32'd0, dec_pc}, {32'd0, e.pc});
        chk("dec_warp",  {59'd0, dec_warp_num}, {59'd0, e.warp});
        chk("dec_split", {60'd0, dec_split_table_num}, {60'd0, e.split});
        chk("dec_fault", {63'd0, dec_fault}, {63'd0, e.fault});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    skd_valid = 1'b0;
    skd_pc = '0;
    skd_warp_num = '0;
    skd_split_table_num = '0;
    icache_req_ready = 1'b0;
    icache_rsp_valid = 1'b0;
    icache_rsp_data = '0;
    flush = 1'b0;
    dec_ready = 1'b1;

    mid();
    chk("rst_skd_ready", {63'd0, skd_ready}, 64'd0);
    chk("rst_req_valid", {63'd0, icache_req_valid}, 64'd0);
    chk("rst_req_addr",  {32'd0, icache_req_addr}, 64'd0);
    chk("rst_dec_valid", {63'd0, dec_valid}, 64'd0);
    chk("rst_dec_pc",    {32'd0, dec_pc}, 64'd0);
    chk("rst_dec_fault", {63'd0, dec_fault}, 64'd0);
    cyc();
    rst = 1'b0;
    mid();
    chk("idle_ready", {63'd0, skd_ready}, 64'd1);

    // basic fetch, zero-wait icache
    cyc();
    offer(32'h1000, 5'd3, 4'd2);
    icache_req_ready = 1'b1;
    push(32'h13, 32'h1000, 5'd3, 4'd2, 1'b0);
    mid();
    chk("b_ready_N", {63'd0, skd_ready}, 64'd1);
    cyc();
    skd_valid = 1'b0;
    mid();
    chk("b_req_valid", {63'd0, icache_req_valid}, 64'd1);
    chk("b_req_addr", {32'd0, icache_req_addr}, 64'h1000);
    chk("b_ready_N1", {63'd0, skd_ready}, 64'd0);
    cyc();
    icache_rsp_valid = 1'b1;
    icache_rsp_data = 32'h13;
    mid();
    chk("b_req_off", {63'd0, icache_req_valid}, 64'd0);
    chk("b_ready_N2", {63'd0, skd_ready}, 64'd0);
    chk("b_dv_N2", {63'd0, dec_valid}, 64'd0);
    cyc();
    icache_rsp_valid = 1'b0;
    mid();
    chk("b_dv_N3", {63'd0, dec_valid}, 64'd1);
    chk("b_ready_N3", {63'd0, skd_ready}, 64'd0);
    cyc();
    mid();
    chk("b_ready_N4", {63'd0, skd_ready}, 64'd1);
    chk("b_dv_N4", {63'd0, dec_valid}, 64'd0);

    // icache backpressure
    cyc();
    offer(32'h2000, 5'd7, 4'd5);
    icache_req_ready = 1'b0;
    push(32'h0050_0093, 32'h2000, 5'd7, 4'd5, 1'b0);
    cyc();
    skd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("bp_req_valid", {63'd0, icache_req_valid}, 64'd1);
      chk("bp_req_addr", {32'd0, icache_req_addr}, 64'h2000);
      cyc();
    end
    icache_req_ready = 1'b1;
    mid();
    chk("bp_req_last", {63'd0, icache_req_valid}, 64'd1);
    cyc();
    mid();
    chk("bp_one_req", {63'd0, icache_req_valid}, 64'd0);
    cyc();
    icache_rsp_valid = 1'b1;
    icache_rsp_data = 32'h0050_0093;
    cyc();
    icache_rsp_valid = 1'b0;
    mid();
    chk("bp_dv", {63'd0, dec_valid}, 64'd1);
    cyc();

    // decode stall
    offer(32'h3000, 5'd1, 4'd9);
    dec_ready = 1'b0;
    push(32'h00A0_0113, 32'h3000, 5'd1, 4'd9, 1'b0);
    cyc();
    skd_valid = 1'b0;
    cyc();
    icache_rsp_valid = 1'b1;
    icache_rsp_data = 32'h00A0_0113;
    cyc();
    icache_rsp_valid = 1'b0;
    icache_rsp_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("st_dv", {63'd0, dec_valid}, 64'd1);
      chk("st_inst", {32'd0, dec_inst}, 64'h00A0_0113);
      chk("st_pc", {32'd0, dec_pc}, 64'h3000);
      chk("st_ready", {63'd0, skd_ready}, 64'd0);
      cyc();
    end
    dec_ready = 1'b1;
    cyc();
    mid();
    chk("st_idle", {63'd0, skd_ready}, 64'd1);
    chk("st_dv_off", {63'd0, dec_valid}, 64'd0);

    // flush in WAIT, late response discarded
    cyc();
    offer(32'h4000, 5'd2, 4'd3);
    cyc();
    skd_valid = 1'b0;
    cyc();
    flush = 1'b1;
    mid();
    chk("fw_ready_w", {63'd0, skd_ready}, 64'd0);
    cyc();
    flush = 1'b0;
    mid();
    chk("fw_ready_d1", {63'd0, skd_ready}, 64'd0);
    chk("fw_req_d1", {63'd0, icache_req_valid}, 64'd0);
    cyc();
    icache_rsp_valid = 1'b1;
    icache_rsp_data = 32'hDEAD_BEEF;
    mid();
    chk("fw_ready_d2", {63'd0, skd_ready}, 64'd0);
    cyc();
    icache_rsp_valid = 1'b0;
    mid();
    chk("fw_ready_after", {63'd0, skd_ready}, 64'd1);
    chk("fw_no_dv", {63'd0, dec_valid}, 64'd0);
    cyc();
    mid();
    chk("fw_no_dv2", {63'd0, dec_valid}, 64'd0);

    // asynchronous reset in WAIT
    cyc();
    offer(32'h5000, 5'd9, 4'd4);
    cyc();
    skd_valid = 1'b0;
    cyc();
    #2;
    rst = 1'b1;
    #1;
    chk("ar_req_valid", {63'd0, icache_req_valid}, 64'd0);
    chk("ar_req_addr", {32'd0, icache_req_addr}, 64'd0);
    chk("ar_skd_ready", {63'd0, skd_ready}, 64'd0);
    chk("ar_dec_valid", {63'd0, dec_valid}, 64'd0);
    chk("ar_dec_pc", {32'd0, dec_pc}, 64'd0);
    chk("ar_dec_warp", {59'd0, dec_warp_num}, 64'd0);
    cyc();
    rst = 1'b0;
    cyc();
    icache_rsp_valid = 1'b1;
    icache_rsp_data = 32'h0000_0BAD;
    mid();
    chk("ar_late_dv", {63'd0, dec_valid}, 64'd0);
    cyc();
    icache_rsp_valid = 1'b0;
    mid();
    chk("ar_late_dv2", {63'd0, dec_valid}, 64'd0);
    chk("ar_idle", {63'd0, skd_ready}, 64'd1);

    // flush in OUT beats dec_ready
    cyc();
    offer(32'h6000, 5'd4, 4'd6);
    cyc();
    skd_valid = 1'b0;
    cyc();
    icache_rsp_valid = 1'b1;
    icache_rsp_data = 32'h1111_2222;
    cyc();
    icache_rsp_valid = 1'b0;
    flush = 1'b1;
    mid();
    chk("fo_dv", {63'd0, dec_valid}, 64'd1);
    chk("fo_ready", {63'd0, skd_ready}, 64'd0);
    cyc();
    flush = 1'b0;
    mid();
    chk("fo_dv_drop", {63'd0, dec_valid}, 64'd0);
    chk("fo_idle", {63'd0, skd_ready}, 64'd1);

    // flush in REQ without acceptance; flush also blocks IDLE ready
    cyc();
    offer(32'h7000, 5'd5, 4'd7);
    icache_req_ready = 1'b0;
    cyc();
    skd_valid = 1'b0;
    flush = 1'b1;
    mid();
    chk("fr_req", {63'd0, icache_req_valid}, 64'd1);
    cyc();
    mid();
    chk("fr_no_req", {63'd0, icache_req_valid}, 64'd0);
    chk("fi_ready_flush", {63'd0, skd_ready}, 64'd0);
    cyc();
    flush = 1'b0;
    icache_req_ready = 1'b1;
    mid();
    chk("fr_idle", {63'd0, skd_ready}, 64'd1);
    chk("fr_no_dv", {63'd0, dec_valid}, 64'd0);

    // misaligned pc
    cyc();
    offer(32'h1002, 5'd4, 4'd1);
`ifdef GELATO_IFETCH_ALIGN_CHECK_EN
    push(32'h0, 32'h1002, 5'd4, 4'd1, 1'b1);
    cyc();
    skd_valid = 1'b0;
    mid();
    chk("al_no_req", {63'd0, icache_req_valid}, 64'd0);
    chk("al_dv", {63'd0, dec_valid}, 64'd1);
    cyc();
    mid();
    chk("al_no_req2", {63'd0, icache_req_valid}, 64'd0);
    chk("al_idle", {63'd0, skd_ready}, 64'd1);
`else
    push(32'h0000_0073, 32'h1002, 5'd4, 4'd1, 1'b0);
    cyc();
    skd_valid = 1'b0;
    mid();
    chk("ma_req", {63'd0, icache_req_valid}, 64'd1);
    chk("ma_addr", {32'd0, icache_req_addr}, 64'h1002);
    cyc();
    icache_rsp_valid = 1'b1;
    icache_rsp_data = 32'h0000_0073;
    cyc();
    icache_rsp_valid = 1'b0;
    mid();
    chk("ma_dv", {63'd0, dec_valid}, 64'd1);
    cyc();
    mid();
    chk("ma_idle", {63'd0, skd_ready}, 64'd1);
`endif

    cyc();
    mid();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
